mem_channel_arbiter: RTL and testbench
======================================

// Module: mem_channel_arbiter
// PURPOSE
//   Shares one off-chip memory channel between two HLS-style masters. Masters use the
//   level-held oe/we/addr/wdata/size protocol and wait for a one-cycle DataRdy pulse.
//   Round-robin grant, held for the whole transaction.
//   Sits between the accelerator Mout_* ports and the memory model/slave.
//   Includes a watchdog that aborts a stuck transaction.
// PARAMETERS
//   ADDR_W          8    address width per channel
//   DATA_W          32   data width per channel
//   SIZE_W          6    data_ram_size width (access size in bits)
//   TIMEOUT_CYCLES  64   max BUSY cycles without s_rdy before abort (>=2)
// PORTS
//   clock        in   1        rising-edge clock
//   reset        in   1        synchronous, active-high
//   m0_oe        in   1        master 0 read request (held until m0_rdy)
//   m0_we        in   1        master 0 write request (held until m0_rdy)
//   m0_addr      in   ADDR_W   master 0 address
//   m0_wdata     in   DATA_W   master 0 write data
//   m0_size      in   SIZE_W   master 0 access size
//   m0_rdata     out  DATA_W   read data to master 0
//   m0_rdy       out  1        DataRdy to master 0
//   m1_*         -    -        same set as m0_* for master 1
//   s_oe, s_we   out  1        to slave
//   s_addr       out  ADDR_W   to slave
//   s_wdata      out  DATA_W   to slave
//   s_size       out  SIZE_W   to slave
//   s_rdata      in   DATA_W   read data from slave, valid with s_rdy
//   s_rdy        in   1        DataRdy from slave
//   busy         out  1        1 while FSM in BUSY
//   timeout_err  out  1        sticky: a transaction was aborted
//   proto_err    out  1        sticky: a master raised oe and we together
// BEHAVIOUR
//   - Registers: state {IDLE,BUSY}, owner (1b), last_owner (1b), wdog counter
//     (clog2(TIMEOUT_CYCLES+1) bits), timeout_err, proto_err.
//   - Reset: state=IDLE, owner=0, last_owner=1 (m0 wins the first tie), wdog=0,
//     errors=0. All outputs read 0 on the cycle after the reset edge.
//   - IDLE: req_i = mi_oe|mi_we. One requester: grant it. Both: grant ~last_owner.
//     On the edge: state<=BUSY, owner<=winner, wdog<=0. No request: stay IDLE.
//   - Grant latency is 1 cycle: the request is seen in cycle N; s_* is driven from N+1.
//   - BUSY: s_oe/s_we/s_addr/s_wdata/s_size come combinationally from the owner's
//     inputs. s_rdy is routed to the owner's rdy and s_rdata to the owner's rdata.
//     The non-owner sees rdy=0 and rdata=0. Non-owner requests wait.
//   - IDLE outputs: s_oe=s_we=0, s_addr/s_wdata/s_size=0, m*_rdy=0, m*_rdata=0.
//   - BUSY exit on s_rdy=1: state<=IDLE, last_owner<=owner.
//     There is always exactly one IDLE turnaround cycle between grants.
//   - Watchdog: wdog increments each BUSY cycle without s_rdy.
//     When wdog==TIMEOUT_CYCLES-1 and s_rdy=0: timeout_err<=1, state<=IDLE,
//     last_owner<=owner. The aborted master gets no rdy.
//     s_rdy in that same cycle takes priority: normal completion, no error.
//   - proto_err<=1 when any master has oe&we=1 in a cycle where it is being granted
//     or is the owner. The transaction is forwarded unchanged.
//   - Error flags clear only on reset. busy = (state==BUSY).
//   - A stray s_rdy while IDLE is ignored and not forwarded.
//   - Reset asserted mid-BUSY: abort without rdy; s_oe/s_we are 0 from the next cycle.
// TESTING
//   1. m0 read addr=0x10 at cycle 0; slave s_rdy=1, s_rdata=0xDEADBEEF at cycle 2 ->
//      s_oe=1, s_addr=0x10 in cycles 1-2; m0_rdy=1, m0_rdata=0xDEADBEEF at cycle 2;
//      m1_rdy=0, m1_rdata=0; busy=0 at cycle 3.
//   2. m0 and m1 request together after reset, each held until its rdy -> m0 served
//      first, then m1 after one IDLE cycle. The next simultaneous pair serves m0 again
//      (last_owner=1).
//   3. m1 write addr=0x20, wdata=0x12345678, size=8; s_rdy one cycle after grant ->
//      s_we=1, s_size=8, s_wdata=0x12345678; m1_rdy pulses once; m0 never sees rdy.
//   4. TIMEOUT_CYCLES=16; m0 read; slave never answers -> after 16 BUSY cycles:
//      timeout_err=1, busy=0, m0_rdy never 1. A following m1 request completes
//      normally and timeout_err stays 1.
//   5. reset=1 at the second BUSY cycle of an m0 read -> s_oe=0, busy=0 and errors=0
//      next cycle. The first tie after reset grants m0.
//   6. m0 asserts oe=1 and we=1 together -> proto_err=1 (sticky) and the transaction
//      is still forwarded. Also: s_rdy=1 while IDLE -> m0_rdy=m1_rdy=0, state unchanged.

Source files
------------

// File: rtl/mem_channel_if.sv
// One HLS-style memory channel: level-held oe/we/addr/wdata/size requests answered by a one-cycle rdy pulse.
interface mem_channel_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 6
);
  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [SIZE_W-1:0] size;
  logic [DATA_W-1:0] rdata;
  logic              rdy;

  modport master (output oe, we, addr, wdata, size, input rdata, rdy);
  modport slave  (input oe, we, addr, wdata, size, output rdata, rdy);
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin sharing of one memory channel between two masters, with a watchdog
// that aborts a transaction the slave never answers.
//
//   state | meaning
//   IDLE  | no owner; pick a winner among pending requests (turnaround cycle)
//   BUSY  | owner's request forwarded to the slave until s_rdy or watchdog abort
module mem_channel_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int SIZE_W         = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clock,
  input  logic          reset,
  mem_channel_if.slave  m0,
  mem_channel_if.slave  m1,
  mem_channel_if.master s,
  output logic          busy,
  output logic          timeout_err,
  output logic          proto_err
);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic [WDOG_W-1:0] wdog;

  logic              req0, req1, winner, win_bad, own_bad;
  logic              own_oe, own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [SIZE_W-1:0] own_size;

  always_comb begin
    req0 = m0.oe | m0.we;
    req1 = m1.oe | m1.we;
    // on a tie the master that did not hold the channel last goes first
    if (req0 && req1) winner = ~last_owner;
    else              winner = req1;
    win_bad = winner ? (m1.oe & m1.we) : (m0.oe & m0.we);
    own_bad = owner  ? (m1.oe & m1.we) : (m0.oe & m0.we);
  end

  always_comb begin
    own_oe    = owner ? m1.oe    : m0.oe;
    own_we    = owner ? m1.we    : m0.we;
    own_addr  = owner ? m1.addr  : m0.addr;
    own_wdata = owner ? m1.wdata : m0.wdata;
    own_size  = owner ? m1.size  : m0.size;
  end

  always_comb begin
    s.oe     = 1'b0;
    s.we     = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.size   = '0;
    m0.rdy   = 1'b0;
    m0.rdata = '0;
    m1.rdy   = 1'b0;
    m1.rdata = '0;
    if (state == BUSY) begin
      s.oe    = own_oe;
      s.we    = own_we;
      s.addr  = own_addr;
      s.wdata = own_wdata;
      s.size  = own_size;
      if (owner) begin
        m1.rdy   = s.rdy;
        m1.rdata = s.rdata;
      end else begin
        m0.rdy   = s.rdy;
        m0.rdata = s.rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      wdog        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= BUSY;
            busy  <= 1'b1;
            owner <= winner;
            wdog  <= '0;
            if (win_bad) proto_err <= 1'b1;
          end
        end
        BUSY: begin
          if (own_bad) proto_err <= 1'b1;
          // a completion in the last watchdog cycle still counts as a normal finish
          if (s.rdy) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_owner <= owner;
          end else if (wdog == WDOG_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last_owner  <= owner;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Scoreboarded bench for mem_channel_arbiter: directed master traffic against a
// configurable-latency slave model.
module tb_mem_channel_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 6;
  localparam int TMO    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, timeout_err, proto_err;

  mem_channel_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) m0_if ();
  mem_channel_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) m1_if ();
  mem_channel_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) s_if ();

  always #5 clock = ~clock;

  mem_channel_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .m0(m0_if), .m1(m1_if), .s(s_if),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  typedef struct {
    logic        mid;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_cnt0 = 0, rdy_cnt1 = 0;
  int   seen0 = 0, seen1 = 0;
  int   slv_lat = 0;
  int   slv_cnt = 0;
  logic slv_stray = 1'b0;
  exp_t mon_e;
  logic mon_mid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_data(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // slave model: answers the n-th BUSY cycle of each transaction (n = slv_lat)
  always @(posedge clock) begin
    #4;
    if (slv_stray) begin
      s_if.rdy   = 1'b1;
      s_if.rdata = 32'hBAD0BAD0;
    end else if (s_if.oe || s_if.we) begin
      if (slv_cnt == slv_lat) begin
        s_if.rdy   = 1'b1;
        s_if.rdata = s_if.oe ? slv_data(s_if.addr) : 32'h0;
      end else begin
        s_if.rdy   = 1'b0;
        s_if.rdata = 32'h0;
      end
      slv_cnt++;
    end else begin
      slv_cnt    = 0;
      s_if.rdy   = 1'b0;
      s_if.rdata = 32'h0;
    end
  end

  always @(negedge clock) begin
    if (m0_if.rdy || m1_if.rdy) begin
      check("rdy_excl", {31'b0, m0_if.rdy & m1_if.rdy}, 32'h0);
      mon_mid = m1_if.rdy;
      if (exp_q.size() == 0) begin
        check("rdy_unexpected", 32'h1, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("srv_master", {31'b0, mon_mid}, {31'b0, mon_e.mid});
        check("srv_rdata", mon_mid ? m1_if.rdata : m0_if.rdata, mon_e.data);
        check("nonowner_rdata", mon_mid ? m0_if.rdata : m1_if.rdata, 32'h0);
      end
      if (m0_if.rdy) rdy_cnt0++;
      if (m1_if.rdy) rdy_cnt1++;
    end
  end

  // advance to just after the next edge; a master that saw rdy drops its request
  task automatic tick();
    @(posedge clock);
    #1;
    if (rdy_cnt0 != seen0) begin
      seen0 = rdy_cnt0;
      m0_if.oe = 1'b0;
      m0_if.we = 1'b0;
    end
    if (rdy_cnt1 != seen1) begin
      seen1 = rdy_cnt1;
      m1_if.oe = 1'b0;
      m1_if.we = 1'b0;
    end
    #2;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic issue(input logic mid, input logic oe, input logic we, input logic [7:0] a,
                       input logic [31:0] wd, input logic [5:0] sz);
    if (mid) begin
      m1_if.oe = oe; m1_if.we = we; m1_if.addr = a; m1_if.wdata = wd; m1_if.size = sz;
    end else begin
      m0_if.oe = oe; m0_if.we = we; m0_if.addr = a; m0_if.wdata = wd; m0_if.size = sz;
    end
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      sample();
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'b0, ok}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    issue(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 6'h0);
    issue(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 6'h0);

    // reset state
    tick(); sample();
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_terr", {31'b0, timeout_err}, 32'h0);
    check("rst_perr", {31'b0, proto_err}, 32'h0);
    check("rst_soe", {30'b0, s_if.oe, s_if.we}, 32'h0);
    check("rst_rdy", {30'b0, m0_if.rdy, m1_if.rdy}, 32'h0);
    tick(); reset = 1'b0;

    // m0 read, slave answers in the second BUSY cycle
    slv_lat = 1;
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 6'd32);
    exp_q.push_back('{1'b0, 32'hDEADBEEF});
    sample();
    check("t1_c0_busy", {31'b0, busy}, 32'h0);
    check("t1_c0_soe", {31'b0, s_if.oe}, 32'h0);
    tick(); sample();
    check("t1_c1_soe", {31'b0, s_if.oe}, 32'h1);
    check("t1_c1_addr", {24'b0, s_if.addr}, 32'h10);
    check("t1_c1_busy", {31'b0, busy}, 32'h1);
    check("t1_c1_m0rdy", {31'b0, m0_if.rdy}, 32'h0);
    tick(); sample();
    check("t1_c2_soe", {31'b0, s_if.oe}, 32'h1);
    check("t1_c2_m0rdy", {31'b0, m0_if.rdy}, 32'h1);
    check("t1_c2_m0rdata", m0_if.rdata, 32'hDEADBEEF);
    check("t1_c2_m1rdy", {31'b0, m1_if.rdy}, 32'h0);
    check("t1_c2_m1rdata", m1_if.rdata, 32'h0);
    tick(); sample();
    check("t1_c3_busy", {31'b0, busy}, 32'h0);
    check("t1_c3_soe", {31'b0, s_if.oe}, 32'h0);

    // m1 write, slave answers in the first BUSY cycle
    slv_lat = 0;
    tick();
    issue(1'b1, 1'b0, 1'b1, 8'h20, 32'h12345678, 6'd8);
    exp_q.push_back('{1'b1, 32'h0});
    tick(); sample();
    check("t3_swe", {30'b0, s_if.oe, s_if.we}, 32'h1);
    check("t3_size", {26'b0, s_if.size}, 32'd8);
    check("t3_wdata", s_if.wdata, 32'h12345678);
    check("t3_addr", {24'b0, s_if.addr}, 32'h20);
    check("t3_m1rdy", {31'b0, m1_if.rdy}, 32'h1);
    check("t3_m0rdy", {31'b0, m0_if.rdy}, 32'h0);
    tick(); sample();
    check("t3_after_busy", {31'b0, busy}, 32'h0);
    check("t3_after_m1rdy", {31'b0, m1_if.rdy}, 32'h0);

    // simultaneous requests: m0 first (last owner m1), one IDLE cycle, then m1
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h31, 32'h0, 6'd32);
    issue(1'b1, 1'b1, 1'b0, 8'h42, 32'h0, 6'd32);
    exp_q.push_back('{1'b0, slv_data(8'h31)});
    exp_q.push_back('{1'b1, slv_data(8'h42)});
    tick(); sample();
    check("t2_first_addr", {24'b0, s_if.addr}, 32'h31);
    tick(); sample();
    check("t2_turn_busy", {31'b0, busy}, 32'h0);
    check("t2_turn_soe", {31'b0, s_if.oe}, 32'h0);
    tick(); sample();
    check("t2_second_addr", {24'b0, s_if.addr}, 32'h42);
    check("t2_second_m1rdy", {31'b0, m1_if.rdy}, 32'h1);
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h55, 32'h0, 6'd32);
    issue(1'b1, 1'b1, 1'b0, 8'h66, 32'h0, 6'd32);
    exp_q.push_back('{1'b0, slv_data(8'h55)});
    exp_q.push_back('{1'b1, slv_data(8'h66)});
    wait_idle(20);

    // oe and we together: flagged but forwarded; then a stray s_rdy while IDLE
    tick();
    issue(1'b0, 1'b1, 1'b1, 8'h30, 32'hA5A5A5A5, 6'd4);
    exp_q.push_back('{1'b0, slv_data(8'h30)});
    sample();
    check("t6_c0_perr", {31'b0, proto_err}, 32'h0);
    tick(); sample();
    check("t6_perr", {31'b0, proto_err}, 32'h1);
    check("t6_fwd", {30'b0, s_if.oe, s_if.we}, 32'h3);
    check("t6_wdata", s_if.wdata, 32'hA5A5A5A5);
    tick(); sample();
    check("t6_idle", {31'b0, busy}, 32'h0);
    tick();
    slv_stray = 1'b1;
    sample();
    check("t6_stray_rdy", {30'b0, m0_if.rdy, m1_if.rdy}, 32'h0);
    tick();
    slv_stray = 1'b0;
    sample();
    check("t6_stray_busy", {31'b0, busy}, 32'h0);
    check("t6_perr_sticky", {31'b0, proto_err}, 32'h1);

    // watchdog: slave never answers m0
    slv_lat = 1000;
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h77, 32'h0, 6'd32);
    for (int i = 1; i <= TMO; i++) begin
      tick(); sample();
      check($sformatf("t4_busy_%0d", i), {31'b0, busy}, 32'h1);
      check($sformatf("t4_terr_%0d", i), {31'b0, timeout_err}, 32'h0);
    end
    tick();
    m0_if.oe = 1'b0;
    slv_lat = 0;
    issue(1'b1, 1'b1, 1'b0, 8'h44, 32'h0, 6'd32);
    exp_q.push_back('{1'b1, slv_data(8'h44)});
    sample();
    check("t4_abort_busy", {31'b0, busy}, 32'h0);
    check("t4_abort_terr", {31'b0, timeout_err}, 32'h1);
    check("t4_abort_m0rdy", {31'b0, m0_if.rdy}, 32'h0);
    wait_idle(20);
    check("t4_terr_sticky", {31'b0, timeout_err}, 32'h1);

    // reset in the second BUSY cycle of an m0 read
    slv_lat = 1000;
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h88, 32'h0, 6'd32);
    tick(); tick();
    reset = 1'b1;
    sample();
    check("t5_pre_busy", {31'b0, busy}, 32'h1);
    tick();
    reset = 1'b0;
    m0_if.oe = 1'b0;
    sample();
    check("t5_soe", {31'b0, s_if.oe}, 32'h0);
    check("t5_busy", {31'b0, busy}, 32'h0);
    check("t5_errs", {30'b0, timeout_err, proto_err}, 32'h0);
    check("t5_m0rdy", {31'b0, m0_if.rdy}, 32'h0);
    slv_lat = 0;
    tick();
    issue(1'b0, 1'b1, 1'b0, 8'h21, 32'h0, 6'd32);
    issue(1'b1, 1'b1, 1'b0, 8'h22, 32'h0, 6'd32);
    exp_q.push_back('{1'b0, slv_data(8'h21)});
    exp_q.push_back('{1'b1, slv_data(8'h22)});
    tick(); sample();
    check("t5_tie_addr", {24'b0, s_if.addr}, 32'h21);
    wait_idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
